// File: rtl/wb_cache_ctrl.sv
// wb_cache_ctrl: write-back, write-allocate cache controller with one-word lines,
// 1 or 2 ways (LRU replacement), byte-enabled stores, and a valid/ack memory port
// that tolerates any memory latency, including an ack in the first request cycle.
module wb_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4,
  parameter int SETS       = 16,
  parameter int WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [WORD_BYTES-1:0]   req_be,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [8*WORD_BYTES-1:0] resp_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [8*WORD_BYTES-1:0] mem_rdata,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int OFF_W  = $clog2(WORD_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TAG  = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Replace the enabled bytes of a line with the corresponding store bytes.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [WORD_BYTES-1:0] be);
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Control state
  logic [2:0]      state_q;
  logic [SETS-1:0] valid_q [2];
  logic [SETS-1:0] dirty_q [2];
  logic [SETS-1:0] lru_q;
  logic            victim_q;
  logic [31:0]     hit_cnt_q;
  logic [31:0]     miss_cnt_q;

  // Datapath state (never reset)
  logic                  req_we_q;
  logic [WORD_BYTES-1:0] req_be_q;
  logic [LINE_W-1:0]     req_line_q;
  logic [DATA_W-1:0]     req_wdata_q;
  logic [TAG_W-1:0]      tag_q  [2][SETS];
  logic [DATA_W-1:0]     data_q [2][SETS];
  logic [DATA_W-1:0]     done_data_q;

  // Byte offset within the word does not affect a one-word line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[OFF_W-1:0];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit0, hit1, hit, hit_way;
  logic              miss_victim, victim_dirty;
  logic [DATA_W-1:0] hit_data, store_merge, fill_data;

  assign idx     = req_line_q[IDX_W-1:0];
  assign req_tag = req_line_q[LINE_W-1:IDX_W];

  // Tag lookup, victim choice and merged data for the latched request.
  always_comb begin
    hit0 = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
    hit1 = (WAYS == 2) && valid_q[1][idx] && (tag_q[1][idx] == req_tag);
    hit      = hit0 || hit1;
    hit_way  = hit1 && !hit0;
    hit_data = data_q[hit_way][idx];
    store_merge = merge_bytes(hit_data, req_wdata_q, req_be_q);
    if (!valid_q[0][idx]) begin
      miss_victim = 1'b0;
    end else if (WAYS == 2) begin
      miss_victim = valid_q[1][idx] ? lru_q[idx] : 1'b1;
    end else begin
      miss_victim = 1'b0;
    end
    victim_dirty = valid_q[miss_victim][idx] && dirty_q[miss_victim][idx];
    fill_data    = req_we_q ? merge_bytes(mem_rdata, req_wdata_q, req_be_q) : mem_rdata;
  end

  // Miss-handling FSM plus valid/dirty/LRU bookkeeping and statistics.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      for (int w = 0; w < 2; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      lru_q      <= '0;
      victim_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) state_q <= S_TAG;
        S_TAG: begin
          if (hit) begin
            if (req_we_q) dirty_q[hit_way][idx] <= 1'b1;
            lru_q[idx] <= ~hit_way;
            hit_cnt_q  <= sat_inc(hit_cnt_q);
            state_q    <= S_IDLE;
          end else begin
            victim_q   <= miss_victim;
            miss_cnt_q <= sat_inc(miss_cnt_q);
            state_q    <= victim_dirty ? S_WB : S_FILL;
          end
        end
        S_WB: if (mem_ack) state_q <= S_FILL;
        S_FILL: begin
          if (mem_ack) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= req_we_q;
            lru_q[idx]             <= ~victim_q;
            state_q                <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Request capture, store-hit merge and refill install into the data/tag arrays.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      req_we_q    <= req_we;
      req_be_q    <= req_be;
      req_line_q  <= req_addr[ADDR_W-1:OFF_W];
      req_wdata_q <= req_wdata;
    end
    if (state_q == S_TAG && hit && req_we_q) begin
      data_q[hit_way][idx] <= store_merge;
    end
    if (state_q == S_FILL && mem_ack) begin
      data_q[victim_q][idx] <= fill_data;
      tag_q[victim_q][idx]  <= req_tag;
      done_data_q           <= fill_data;
    end
  end

  // Outputs decode from state only, so reset forces them to idle values at once.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_TAG: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = req_we_q ? store_merge : hit_data;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[victim_q][idx], idx, {OFF_W{1'b0}}};
        mem_wdata = data_q[victim_q][idx];
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, {OFF_W{1'b0}}};
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = done_data_q;
      end
      default: ;
    endcase
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// tb_wb_cache_ctrl: directed vector table for the main cache scenarios, a reset
// during refill, then random traffic against a behavioural cache/memory model.
module tb_wb_cache_ctrl;
  localparam int ADDR_W = 32, WORD_BYTES = 4, SETS = 4, WAYS = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  wb_cache_ctrl #(.ADDR_W(ADDR_W), .WORD_BYTES(WORD_BYTES), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int ack_lat = 0;
  int stab_err = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  txn_t txn_q[$];

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        miss;
    logic        wb;
    logic [31:0] rdata;
    int          rlat;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [31:0] fill_addr;
    int          hits;
    int          misses;
  } vec_t;

  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h20:  return 32'h11223344;
      32'h50:  return 32'h55555050;
      32'h90:  return 32'h99990090;
      32'hD0:  return 32'hDDDD00D0;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_lat wait cycles, records every transaction.
  initial begin
    int          wait_cnt;
    logic [31:0] cap_a, cap_d;
    logic        cap_we;
    wait_cnt = -1;
    cap_a = '0; cap_d = '0; cap_we = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!mem_req) begin
        wait_cnt = -1;
      end else begin
        if (wait_cnt < 0) begin
          wait_cnt = ack_lat;
          cap_a = mem_addr; cap_d = mem_wdata; cap_we = mem_we;
        end else if (mem_addr !== cap_a || mem_we !== cap_we || mem_wdata !== cap_d) begin
          stab_err++;
        end
        if (wait_cnt == 0) begin
          txn_q.push_back('{mem_we, mem_addr, mem_wdata});
          if (mem_we) dut_mem[mem_addr] = mem_wdata;
          else mem_rdata = dut_mem.exists(mem_addr) ? dut_mem[mem_addr] : mem_init(mem_addr);
          mem_ack  = 1'b1;
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Behavioural model: per set, resident lines plus the most recently used way.
  logic        m_valid [4][2];
  logic        m_dirty [4][2];
  logic [31:0] m_addr  [4][2];
  logic [31:0] m_data  [4][2];
  int          m_mru   [4];
  int          m_hits, m_misses;

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
      end
      m_mru[s] = 0;
    end
    m_hits = 0; m_misses = 0;
  endtask

  task automatic model_step(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, output vec_t v);
    logic [31:0] a, d;
    int s, hw, vw;
    a = addr & ~32'h3;
    s = int'(addr[3:2]);
    hw = -1;
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_addr[s][w] == a) hw = w;
    v = '{we, be, addr, wdata, lat, 1'b0, 1'b0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0, 0};
    if (hw >= 0) begin
      if (we) begin
        m_data[s][hw]  = tb_merge(m_data[s][hw], wdata, be);
        m_dirty[s][hw] = 1'b1;
      end
      v.rdata  = m_data[s][hw];
      m_mru[s] = hw;
      m_hits++;
    end else begin
      if (!m_valid[s][0]) vw = 0;
      else if (!m_valid[s][1]) vw = 1;
      else vw = (m_mru[s] == 0) ? 1 : 0;
      v.miss = 1'b1;
      m_misses++;
      if (m_valid[s][vw] && m_dirty[s][vw]) begin
        v.wb = 1'b1;
        v.wb_addr = m_addr[s][vw];
        v.wb_data = m_data[s][vw];
        ref_mem[m_addr[s][vw]] = m_data[s][vw];
      end
      d = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
      if (we) d = tb_merge(d, wdata, be);
      m_valid[s][vw] = 1'b1; m_dirty[s][vw] = we;
      m_addr[s][vw] = a; m_data[s][vw] = d;
      m_mru[s] = vw;
      v.rdata = d;
      v.fill_addr = a;
      v.rlat = v.wb ? 4 + 2 * lat : 3 + lat;
    end
    v.hits = m_hits;
    v.misses = m_misses;
  endtask

  // Issue one request, wait for its response and compare everything it produced.
  task automatic apply_vec(input string tag, input vec_t v);
    logic [31:0] rd;
    int lat_seen, req_cycles, base, n, exp_n, k, g;
    base = txn_q.size();
    ack_lat = v.lat;
    @(posedge clk); #1;
    g = 0;
    while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_be = v.be; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_be = 4'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    rd = '0; lat_seen = 0; req_cycles = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (resp_valid) begin rd = resp_rdata; lat_seen = c; break; end
    end
    check({tag, " rdata"}, rd, v.rdata);
    check({tag, " latency"}, 32'(lat_seen), 32'(v.rlat));
    n = txn_q.size() - base;
    exp_n = int'(v.miss) + int'(v.wb);
    check({tag, " mem txns"}, 32'(n), 32'(exp_n));
    check({tag, " mem_req cycles"}, 32'(req_cycles), 32'(exp_n * (v.lat + 1)));
    if (n == exp_n) begin
      k = base;
      if (v.wb) begin
        check({tag, " wb we"}, 32'(txn_q[k].we), 32'd1);
        check({tag, " wb addr"}, txn_q[k].addr, v.wb_addr);
        check({tag, " wb data"}, txn_q[k].wdata, v.wb_data);
        k++;
      end
      if (v.miss) begin
        check({tag, " fill we"}, 32'(txn_q[k].we), 32'd0);
        check({tag, " fill addr"}, txn_q[k].addr, v.fill_addr);
      end
    end
    @(posedge clk); #1;
    check({tag, " hit_cnt"}, hit_cnt, 32'(v.hits));
    check({tag, " miss_cnt"}, miss_cnt, 32'(v.misses));
  endtask

  vec_t tbl [13];
  vec_t unused_mv;
  vec_t rv;

  initial begin
    int seen, rcount;
    // we, be, addr, wdata, lat, miss, wb, rdata, rlat, wb_addr, wb_data, fill_addr, hits, misses
    tbl[0]  = '{1'b0, 4'h0, 32'h10, 32'h0,        3, 1'b1, 1'b0, 32'hDEADBEEF, 6, 32'h0,  32'h0,        32'h10, 0, 1};
    tbl[1]  = '{1'b0, 4'h0, 32'h10, 32'h0,        3, 1'b0, 1'b0, 32'hDEADBEEF, 1, 32'h0,  32'h0,        32'h0,  1, 1};
    tbl[2]  = '{1'b1, 4'h3, 32'h10, 32'h00001234, 3, 1'b0, 1'b0, 32'hDEAD1234, 1, 32'h0,  32'h0,        32'h0,  2, 1};
    tbl[3]  = '{1'b0, 4'h0, 32'h10, 32'h0,        2, 1'b0, 1'b0, 32'hDEAD1234, 1, 32'h0,  32'h0,        32'h0,  3, 1};
    tbl[4]  = '{1'b0, 4'h0, 32'h50, 32'h0,        1, 1'b1, 1'b0, 32'h55555050, 4, 32'h0,  32'h0,        32'h50, 3, 2};
    tbl[5]  = '{1'b0, 4'h0, 32'h10, 32'h0,        1, 1'b0, 1'b0, 32'hDEAD1234, 1, 32'h0,  32'h0,        32'h0,  4, 2};
    tbl[6]  = '{1'b0, 4'h0, 32'h90, 32'h0,        2, 1'b1, 1'b0, 32'h99990090, 5, 32'h0,  32'h0,        32'h90, 4, 3};
    tbl[7]  = '{1'b0, 4'h0, 32'hD0, 32'h0,        1, 1'b1, 1'b1, 32'hDDDD00D0, 6, 32'h10, 32'hDEAD1234, 32'hD0, 4, 4};
    tbl[8]  = '{1'b1, 4'h8, 32'h20, 32'hAB000000, 2, 1'b1, 1'b0, 32'hAB223344, 5, 32'h0,  32'h0,        32'h20, 4, 5};
    tbl[9]  = '{1'b0, 4'h0, 32'h50, 32'h0,        0, 1'b1, 1'b0, 32'h55555050, 3, 32'h0,  32'h0,        32'h50, 4, 6};
    tbl[10] = '{1'b0, 4'h0, 32'h10, 32'h0,        0, 1'b1, 1'b1, 32'hDEAD1234, 4, 32'h20, 32'hAB223344, 32'h10, 4, 7};
    tbl[11] = '{1'b0, 4'h0, 32'h20, 32'h0,        1, 1'b1, 1'b0, 32'hAB223344, 4, 32'h0,  32'h0,        32'h20, 4, 8};
    tbl[12] = '{1'b0, 4'h0, 32'h10, 32'h0,        1, 1'b0, 1'b0, 32'hDEAD1234, 1, 32'h0,  32'h0,        32'h0,  5, 8};

    rst_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = '0; req_addr = '0; req_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset hit_cnt", hit_cnt, 32'd0);
    check("reset miss_cnt", miss_cnt, 32'd0);
    rst_b = 1'b1;

    for (int i = 0; i < 13; i++) begin
      model_step(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].lat, unused_mv);
      apply_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset asserted while a refill is outstanding.
    ack_lat = 10;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mem_req) begin seen = c; break; end
    end
    check("rst fill start cycle", 32'(seen), 32'd2);
    @(posedge clk); #3;
    rst_b = 1'b0;
    #1;
    check("rst mem_req async", 32'(mem_req), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst mem_addr", mem_addr, 32'd0);
    rcount = 0;
    repeat (2) begin @(negedge clk); if (resp_valid || mem_req) rcount++; end
    rst_b = 1'b1;
    check("rst hit_cnt", hit_cnt, 32'd0);
    check("rst miss_cnt", miss_cnt, 32'd0);
    repeat (4) begin @(negedge clk); if (resp_valid || mem_req) rcount++; end
    check("rst no response", 32'(rcount), 32'd0);
    model_reset();
    model_step(1'b0, 4'h0, 32'h10, 32'h0, 1, rv);
    apply_vec("post_rst load", rv);
    check("post_rst load missed", miss_cnt, 32'd1);

    // Random traffic over a few conflicting tags in every set.
    for (int i = 0; i < 250; i++) begin
      logic        we;
      logic [3:0]  be;
      logic [31:0] a, wd;
      int          lat;
      we  = ($urandom_range(0, 99) < 40);
      be  = 4'($urandom);
      a   = 32'($urandom_range(0, 4)) * 32'h10 + 32'($urandom_range(0, 3)) * 32'h4
            + 32'($urandom_range(0, 3));
      wd  = $urandom;
      lat = int'($urandom_range(0, 3));
      model_step(we, be, a, wd, lat, rv);
      apply_vec($sformatf("rand%0d", i), rv);
    end

    check("mem bus held until ack", 32'(stab_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
